seg_disp_sched: RTL

- Display scheduler in front of the 6-digit dynamic 7-segment driver.
- Shares the single display between three sources:
  - error/alarm code (highest priority, blinking);
  - inference result (timed, one-deep queued);
  - background value (default, live).
- Drives the driver's data/point/sign/seg_en inputs; holds each timed message for a fixed number of milliseconds.

---
 rtl/seg_disp_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - Display scheduler sharing one 7-segment driver between error, result and background sources
module seg_disp_sched #(
    parameter logic [15:0] CNT_1MS  = 16'd49_999,
    parameter logic [15:0] HOLD_MS  = 16'd2000,
    parameter logic [15:0] BLINK_MS = 16'd250
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        disp_on,
    input  logic        err_req,
    input  logic [19:0] err_code,
    input  logic        res_req,
    input  logic [19:0] res_data,
    input  logic [5:0]  res_point,
    input  logic        res_sign,
    input  logic [19:0] bg_data,
    input  logic [5:0]  bg_point,
    input  logic        bg_sign,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic [1:0]  cur_src,
    output logic        res_ack,
    output logic        err_ack
);

    localparam logic [15:0] HOLD_EFF   = (HOLD_MS == 16'd0) ? 16'd1 : HOLD_MS;
    localparam logic [15:0] HOLD_LAST  = HOLD_EFF - 16'd1;
    localparam logic [15:0] BLINK_LAST = (BLINK_MS == 16'd0) ? 16'd0 : BLINK_MS - 16'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_RES = 2'd1,
        SHOW_ERR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] res_data_q, err_code_q;
    logic [5:0]  res_point_q;
    logic        res_sign_q;
    logic        res_pend_q, res_pend_d;
    logic        err_pend_q, err_pend_d;
    logic        res_ack_q, err_ack_q;
    logic [19:0] data_q, data_d;
    logic [5:0]  point_q, point_d;
    logic        sign_q, sign_d;
    logic        seg_en_q, seg_en_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] ms_q, ms_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        blink_q, blink_d;
    logic        tick, expire;
    logic        go_err, go_res, go_bg;

    assign tick   = (pre_q == CNT_1MS);
    assign expire = tick && (ms_q == HOLD_LAST);

    always_comb begin
        go_err = 1'b0;
        go_res = 1'b0;
        go_bg  = 1'b0;
        case (state_q)
            IDLE: begin
                if (err_pend_q)      go_err = 1'b1;
                else if (res_pend_q) go_res = 1'b1;
                else                 go_bg  = 1'b1;
            end
            SHOW_RES: begin
                if (err_pend_q)      go_err = 1'b1;
                else if (res_pend_q) go_res = 1'b1;
                else if (expire)     go_bg  = 1'b1;
            end
            SHOW_ERR: begin
                if (err_pend_q) go_err = 1'b1;
                else if (expire) begin
                    if (res_pend_q) go_res = 1'b1;
                    else            go_bg  = 1'b1;
                end
            end
            default: go_bg = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        point_d = point_q;
        sign_d  = sign_q;
        src_d   = src_q;
        if (go_err) begin
            state_d = SHOW_ERR;
            data_d  = err_code_q;
            point_d = 6'd0;
            sign_d  = 1'b0;
            src_d   = 2'd2;
        end else if (go_res) begin
            state_d = SHOW_RES;
            data_d  = res_data_q;
            point_d = res_point_q;
            sign_d  = res_sign_q;
            src_d   = 2'd1;
        end else if (go_bg) begin
            state_d = IDLE;
            data_d  = bg_data;
            point_d = bg_point;
            sign_d  = bg_sign;
            src_d   = 2'd0;
        end
    end

    // A request landing on the consuming edge wins: the flag stays set for the newer sample.
    always_comb begin
        res_pend_d = res_pend_q;
        err_pend_d = err_pend_q;
        if (go_res) res_pend_d = 1'b0;
        if (go_err) err_pend_d = 1'b0;
        if (res_req) res_pend_d = 1'b1;
        if (err_req) err_pend_d = 1'b1;
    end

    always_comb begin
        pre_d   = pre_q;
        ms_d    = ms_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if (go_err || go_res || go_bg) begin
            pre_d   = 16'd0;
            ms_d    = 16'd0;
            bcnt_d  = 16'd0;
            blink_d = 1'b1;
        end else if (tick) begin
            pre_d = 16'd0;
            ms_d  = ms_q + 16'd1;
            if (BLINK_MS != 16'd0) begin
                if (bcnt_q == BLINK_LAST) begin
                    bcnt_d  = 16'd0;
                    blink_d = ~blink_q;
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                end
            end
        end else begin
            pre_d = pre_q + 16'd1;
        end
        seg_en_d = disp_on & ((state_d == SHOW_ERR) ? blink_d : 1'b1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            res_data_q  <= 20'd0;
            res_point_q <= 6'd0;
            res_sign_q  <= 1'b0;
            err_code_q  <= 20'd0;
            res_pend_q  <= 1'b0;
            err_pend_q  <= 1'b0;
            res_ack_q   <= 1'b0;
            err_ack_q   <= 1'b0;
            data_q      <= 20'd0;
            point_q     <= 6'd0;
            sign_q      <= 1'b0;
            seg_en_q    <= 1'b0;
            src_q       <= 2'd0;
            pre_q       <= 16'd0;
            ms_q        <= 16'd0;
            bcnt_q      <= 16'd0;
            blink_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            res_pend_q <= res_pend_d;
            err_pend_q <= err_pend_d;
            res_ack_q  <= res_req;
            err_ack_q  <= err_req;
            if (res_req) begin
                res_data_q  <= res_data;
                res_point_q <= res_point;
                res_sign_q  <= res_sign;
            end
            if (err_req) err_code_q <= err_code;
            data_q   <= data_d;
            point_q  <= point_d;
            sign_q   <= sign_d;
            seg_en_q <= seg_en_d;
            src_q    <= src_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
        end
    end

    assign data    = data_q;
    assign point   = point_q;
    assign sign    = sign_q;
    assign seg_en  = seg_en_q;
    assign cur_src = src_q;
    assign res_ack = res_ack_q;
    assign err_ack = err_ack_q;

endmodule
